// File: rtl/ddr_tx_serializer_if.sv
// rtl/ddr_tx_serializer_if.sv - word handshake and serial output bundle for ddr_tx_serializer
interface ddr_tx_serializer_if;
  logic        ser_en;
  logic        scl_pos_edge;
  logic        scl_neg_edge;
  logic        ser_valid;
  logic [1:0]  ser_preamble;
  logic [15:0] ser_data;
  logic        ser_ready;
  logic        ser_sdo;
  logic        ser_busy;
  logic        ser_word_done;
  logic [4:0]  ser_bit_idx;

  modport master (
    output ser_en, scl_pos_edge, scl_neg_edge, ser_valid, ser_preamble, ser_data,
    input  ser_ready, ser_sdo, ser_busy, ser_word_done, ser_bit_idx
  );

  modport slave (
    input  ser_en, scl_pos_edge, scl_neg_edge, ser_valid, ser_preamble, ser_data,
    output ser_ready, ser_sdo, ser_busy, ser_word_done, ser_bit_idx
  );
endinterface

// File: rtl/ddr_tx_serializer.sv
// rtl/ddr_tx_serializer.sv - 20-bit framed word serializer, one bit per SCL edge
// Frame is {preamble, data, odd-bit parity, inverted even-bit parity}, sent MSB first.
module ddr_tx_serializer (
  input  logic        i_sys_clk,
  input  logic        i_rst_n,
  input  logic        i_ser_en,
  input  logic        i_scl_pos_edge,
  input  logic        i_scl_neg_edge,
  input  logic        i_ser_valid,
  input  logic [1:0]  i_ser_preamble,
  input  logic [15:0] i_ser_data,
  output logic        o_ser_ready,
  output logic        o_ser_sdo,
  output logic        o_ser_busy,
  output logic        o_ser_word_done,
  output logic [4:0]  o_ser_bit_idx
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic        hold_valid_q, hold_valid_d;
  logic [19:0] hold_frame_q, hold_frame_d;
  logic [19:0] shift_q, shift_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic        sdo_q, sdo_d;
  logic        done_q, done_d;

  logic [19:0] new_frame;
  logic        scl_edge;
  logic        last_bit;
  logic        accept;

  assign new_frame = {i_ser_preamble, i_ser_data,
                      ^(i_ser_data & 16'hAAAA), ~^(i_ser_data & 16'h5555)};
  assign scl_edge  = i_scl_pos_edge | i_scl_neg_edge;
  assign last_bit  = (state_q == SHIFT) && scl_edge && (bit_idx_q == 5'd19);
  assign accept    = i_ser_valid && o_ser_ready;

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_frame_d = hold_frame_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    sdo_d        = sdo_q;
    done_d       = 1'b0;

    if (!i_ser_en) begin
      state_d      = IDLE;
      hold_valid_d = 1'b0;
      bit_idx_d    = 5'd0;
      sdo_d        = 1'b1;
    end else begin
      if (state_q == SHIFT && scl_edge) begin
        sdo_d     = shift_q[19];
        shift_d   = {shift_q[18:0], 1'b0};
        bit_idx_d = bit_idx_q + 5'd1;
        if (last_bit) begin
          done_d    = 1'b1;
          bit_idx_d = 5'd0;
          if (hold_valid_q) begin
            shift_d      = hold_frame_q;
            hold_valid_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      // A word arriving as the shifter empties goes straight in, so there is no gap.
      if (accept) begin
        if (state_q == IDLE || (last_bit && !hold_valid_q)) begin
          shift_d = new_frame;
          state_d = SHIFT;
        end else begin
          hold_frame_d = new_frame;
          hold_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_frame_q <= 20'd0;
      shift_q      <= 20'd0;
      bit_idx_q    <= 5'd0;
      sdo_q        <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_frame_q <= hold_frame_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      sdo_q        <= sdo_d;
      done_q       <= done_d;
    end
  end

  assign o_ser_ready     = i_ser_en && !hold_valid_q;
  assign o_ser_sdo       = sdo_q;
  assign o_ser_busy      = (state_q == SHIFT);
  assign o_ser_word_done = done_q;
  assign o_ser_bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// tb/tb_ddr_tx_serializer.sv - directed and random checks of ddr_tx_serializer against a frame-queue model
module tb_ddr_tx_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ddr_tx_serializer_if sif();

  always #5 clk = ~clk;

  ddr_tx_serializer dut (
    .i_sys_clk       (clk),
    .i_rst_n         (rst_n),
    .i_ser_en        (sif.ser_en),
    .i_scl_pos_edge  (sif.scl_pos_edge),
    .i_scl_neg_edge  (sif.scl_neg_edge),
    .i_ser_valid     (sif.ser_valid),
    .i_ser_preamble  (sif.ser_preamble),
    .i_ser_data      (sif.ser_data),
    .o_ser_ready     (sif.ser_ready),
    .o_ser_sdo       (sif.ser_sdo),
    .o_ser_busy      (sif.ser_busy),
    .o_ser_word_done (sif.ser_word_done),
    .o_ser_bit_idx   (sif.ser_bit_idx)
  );

  // Model: queue of whole frames awaiting transmission (front = frame being sent).
  logic [19:0] mq[$];
  int          m_pos;
  logic        m_sdo;
  logic        m_done;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [19:0] mk_frame(input logic [1:0] p, input logic [15:0] d);
    logic pa1;
    logic pa0;
    pa1 = 1'b0;
    pa0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) pa1 = pa1 ^ d[i];
      else            pa0 = pa0 ^ d[i];
    end
    return {p, d, pa1, pa0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pos  = 0;
    m_sdo  = 1'b1;
    m_done = 1'b0;
  endtask

  task automatic model_step();
    logic [19:0] cur;
    logic        acc;
    if (!sif.ser_en) begin
      mq.delete();
      m_pos  = 0;
      m_sdo  = 1'b1;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      acc = sif.ser_valid && (mq.size() < 2);
      if (mq.size() > 0 && (sif.scl_pos_edge || sif.scl_neg_edge)) begin
        cur   = mq[0];
        m_sdo = cur[19 - m_pos];
        m_pos++;
        if (m_pos == 20) begin
          m_pos  = 0;
          m_done = 1'b1;
          void'(mq.pop_front());
        end
      end
      if (acc) mq.push_back(mk_frame(sif.ser_preamble, sif.ser_data));
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    #1;
    chk("ready", sif.ser_ready, sif.ser_en && (mq.size() < 2));
    @(posedge clk);
    model_step();
    #1;
    chk("sdo", sif.ser_sdo, m_sdo);
    chk("busy", sif.ser_busy, mq.size() > 0);
    chk("word_done", sif.ser_word_done, m_done);
    chk("bit_idx", sif.ser_bit_idx, m_pos);
    @(negedge clk);
  endtask

  task automatic set_edges(input logic p, input logic n);
    sif.scl_pos_edge = p;
    sif.scl_neg_edge = n;
  endtask

  task automatic offer(input logic [1:0] p, input logic [15:0] d);
    sif.ser_valid    = 1'b1;
    sif.ser_preamble = p;
    sif.ser_data     = d;
    tick();
    sif.ser_valid = 1'b0;
  endtask

  logic [19:0] f;
  logic [19:0] cap20;
  logic [39:0] cap40;
  logic [19:0] f1, f2;
  logic [15:0] d1, d2;
  logic        sdo_prev;
  logic [4:0]  idx_prev;
  int          dcnt;

  initial begin
    sif.ser_en       = 1'b0;
    sif.scl_pos_edge = 1'b0;
    sif.scl_neg_edge = 1'b0;
    sif.ser_valid    = 1'b0;
    sif.ser_preamble = 2'b00;
    sif.ser_data     = 16'h0000;
    model_reset();

    // Reset values, ready follows enable during reset
    @(negedge clk);
    #1;
    chk("rst_sdo", sif.ser_sdo, 1'b1);
    chk("rst_busy", sif.ser_busy, 1'b0);
    chk("rst_done", sif.ser_word_done, 1'b0);
    chk("rst_idx", sif.ser_bit_idx, 5'd0);
    chk("rst_ready_en0", sif.ser_ready, 1'b0);
    sif.ser_en = 1'b1;
    #1;
    chk("rst_ready_en1", sif.ser_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Pin the frame builder with hand-computed values
    f = mk_frame(2'b10, 16'hA5A5);
    chk("frame_a5a5", f, 20'hA9695);
    f = mk_frame(2'b00, 16'hFFFF);
    chk("pa_ffff", f[1:0], 2'b01);
    f = mk_frame(2'b00, 16'h0001);
    chk("pa_0001", f[1:0], 2'b00);
    f = mk_frame(2'b00, 16'h0002);
    chk("pa_0002", f[1:0], 2'b11);

    // Single word A5A5, 20 alternating SCL edges
    offer(2'b10, 16'hA5A5);
    cap20 = '0;
    dcnt  = 0;
    for (int i = 0; i < 20; i++) begin
      set_edges(i % 2 == 0, i % 2 == 1);
      tick();
      cap20 = {cap20[18:0], sif.ser_sdo};
      dcnt += int'(sif.ser_word_done);
    end
    set_edges(1'b0, 1'b0);
    chk("single_bits", cap20, 20'hA9695);
    chk("single_done_cnt", dcnt, 1);
    tick();
    chk("single_busy_after", sif.ser_busy, 1'b0);

    // Parity words driven through the DUT
    for (int k = 0; k < 3; k++) begin
      d1 = (k == 0) ? 16'hFFFF : (k == 1) ? 16'h0001 : 16'h0002;
      offer(2'b01, d1);
      for (int i = 0; i < 20; i++) begin
        set_edges(1'b1, i % 3 == 0);
        tick();
        cap20 = {cap20[18:0], sif.ser_sdo};
      end
      set_edges(1'b0, 1'b0);
      chk("parity_word", cap20, (k == 0) ? 20'h7FFFD : (k == 1) ? 20'h40004 : 20'h4000B);
    end

    // Idle edges leave sdo and bit_idx alone
    sdo_prev = sif.ser_sdo;
    idx_prev = sif.ser_bit_idx;
    set_edges(1'b1, 1'b0); tick();
    set_edges(1'b0, 1'b1); tick();
    set_edges(1'b1, 1'b1); tick();
    set_edges(1'b0, 1'b0);
    chk("idle_sdo", sif.ser_sdo, sdo_prev);
    chk("idle_idx", sif.ser_bit_idx, idx_prev);

    // Back-to-back: second word offered at bit 5, 40 seamless bits
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    f1 = mk_frame(2'b11, d1);
    f2 = mk_frame(2'b01, d2);
    offer(2'b11, d1);
    cap40 = '0;
    dcnt  = 0;
    for (int i = 0; i < 5; i++) begin
      set_edges(1'b1, 1'b0);
      tick();
      cap40 = {cap40[38:0], sif.ser_sdo};
    end
    set_edges(1'b0, 1'b0);
    offer(2'b01, d2);
    chk("b2b_ready_low", sif.ser_ready, 1'b0);
    for (int i = 0; i < 35; i++) begin
      set_edges(i % 2 == 1, i % 2 == 0);
      tick();
      cap40 = {cap40[38:0], sif.ser_sdo};
      dcnt += int'(sif.ser_word_done);
    end
    set_edges(1'b0, 1'b0);
    chk("b2b_bits", cap40, {f1, f2});
    chk("b2b_done_cnt", dcnt, 2);

    // Abort at bit 9 with a word held
    offer(2'b10, 16'h1234);
    for (int i = 0; i < 9; i++) begin
      set_edges(1'b1, 1'b0);
      tick();
    end
    set_edges(1'b0, 1'b0);
    offer(2'b01, 16'h5678);
    chk("abort_idx_before", sif.ser_bit_idx, 5'd9);
    sif.ser_en = 1'b0;
    set_edges(1'b1, 1'b0);
    tick();
    set_edges(1'b0, 1'b0);
    chk("abort_sdo", sif.ser_sdo, 1'b1);
    chk("abort_idx", sif.ser_bit_idx, 5'd0);
    chk("abort_busy", sif.ser_busy, 1'b0);
    chk("abort_done", sif.ser_word_done, 1'b0);
    sif.ser_en = 1'b1;
    tick();
    chk("abort_flushed_busy", sif.ser_busy, 1'b0);
    chk("abort_flushed_ready", sif.ser_ready, 1'b1);

    // Asynchronous reset at bit 12
    offer(2'b11, 16'hBEEF);
    for (int i = 0; i < 12; i++) begin
      set_edges(1'b0, 1'b1);
      tick();
    end
    set_edges(1'b0, 1'b0);
    chk("rstmid_idx_before", sif.ser_bit_idx, 5'd12);
    rst_n = 1'b0;
    #1;
    chk("rstmid_sdo", sif.ser_sdo, 1'b1);
    chk("rstmid_busy", sif.ser_busy, 1'b0);
    chk("rstmid_done", sif.ser_word_done, 1'b0);
    chk("rstmid_idx", sif.ser_bit_idx, 5'd0);
    chk("rstmid_ready", sif.ser_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 3));
      sif.ser_en       = ($urandom_range(0, 79) != 0);
      sif.ser_valid    = ($urandom_range(0, 2) == 0);
      sif.ser_preamble = 2'($urandom);
      sif.ser_data     = 16'($urandom);
      set_edges(r[0], r[1]);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
